stage_fetch0_btb: RTL and testbench
===================================

Name: stage_fetch0_btb

Overview:
Next-generation fetch-address generator for the front end. It selects the next instruction word address with the priority csr > decode redirect > BTB prediction > sequential, and issues it to the icache. Adds a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters, trained by decode. Unlike the previous generation, a decode redirect that arrives while fetch1 is stalled is retained rather than dropped.

Parameters:
BTB_ENTRIES, 16, number of BTB entries; must be a power of 2, minimum 2; IDX_W = log2(BTB_ENTRIES).
RESET_PC, 30'h0, word address [31:2] fetched first after reset.

Ports:
clk_core  in  1  core clock
reset_n  in  1  synchronous, active-low reset
fe0_valid  out  1  equals fe0_read_req
fe1_stall  in  1  fetch1 cannot accept a request this cycle
fe0_read_req  out  1  icache request strobe
fe0_read_asid  out  9  csr_satp[30:22]
fe0_read_addr  out  30  word address [31:2] being requested
fe0_pred_taken  out  1  BTB predicts the fetched word is a taken branch
fe0_pred_target  out  30  predicted target; valid when fe0_pred_taken=1
de_setpc  in  1  decode redirect
de_newpc  in  30  decode redirect target
de_btb_update  in  1  decode trains the BTB this cycle
de_btb_pc  in  30  address of the resolved branch
de_btb_taken  in  1  branch outcome
de_btb_target  in  30  resolved target
csr_kill  in  1  squash the request in the current cycle
csr_setpc  in  1  csr redirect
csr_newpc  in  30  csr redirect target
csr_satp  in  32  satp CSR
csr_btb_flush  in  1  invalidate all BTB entries

Behaviour:
- Reset (reset_n=0 at a clk_core edge): pc_q <= RESET_PC; pending_q <= 0; all BTB valid bits <= 0. While reset_n=0, fe0_read_req=0 and fe0_pred_taken=0.
- fe0_read_addr select: csr_setpc ? csr_newpc : de_setpc ? de_newpc : pc_q.
- fe0_read_req = (csr_setpc & ~csr_kill) | (~fe1_stall & ~csr_kill). A kill suppresses every request, including sequential ones.
- Lookup: combinational on fe0_read_addr. idx = addr[IDX_W-1:0]; tag = addr[29:IDX_W].
  - hit = valid[idx] & (tag match).
  - fe0_pred_taken = fe0_read_req & hit & ctr[idx][1].
  - fe0_pred_target = target[idx].
- pc_q update:
  - request issued: pc_q <= fe0_pred_taken ? fe0_pred_target : fe0_read_addr + 1, with 30-bit wrap (3FFFFFFF+1 = 0).
  - no request but csr_setpc or de_setpc: pc_q <= fe0_read_addr, with no increment. The redirect is retained and fetched on the first unstalled cycle.
  - otherwise: pc_q holds.
- Training on de_btb_update, with i = de_btb_pc index:
  - tag hit, taken: ctr saturating +1; target <= de_btb_target.
  - tag hit, not taken: ctr saturating -1. Target and valid are unchanged.
  - miss, taken: allocate the entry (valid=1, new tag, new target, ctr=2'b10), replacing any prior entry.
  - miss, not taken: no change.
- Write timing: BTB writes take effect at the next edge. A same-cycle lookup of the same index sees the old contents.
- csr_btb_flush: all valid bits <= 0 at the next edge. It overrides a simultaneous de_btb_update.
- Latency: request to pc_q advance is 1 cycle; training to visible prediction is 1 cycle.

Decomposition:
- Package fe_pkg:
  - btb_entry_t {valid, tag, target[29:0], ctr[1:0]}.
  - CTR_WEAK_TAKEN = 2'b10.
  - Saturating inc/dec functions.
- Sub-module fe_btb: storage array, combinational lookup port, update/flush port.
- stage_fetch0_btb contains: pc_q, the priority mux and the request logic.

Test Plan:
- Reset, then fe1_stall=0 for 3 cycles -> addrs 0, 1, 2 with fe0_read_req=1 each cycle; fe0_pred_taken=0.
- fe1_stall=1 for 2 cycles at pc 5 -> fe0_read_req=0; pc holds 5; on release, addr 5 is fetched.
- fe1_stall=1 and de_setpc=1 with de_newpc=0x40 for 1 cycle; release after 2 cycles -> next request addr = 0x40.
- BTB training:
  - Stimulus: de_btb_update with pc=0x10, taken=1, target=0x80; then fetch 0x10 -> pred_taken=1, target 0x80, next addr 0x80.
  - Stimulus: 2 not-taken updates -> fetch 0x10 gives pred_taken=0, next addr 0x11.
- csr_setpc=1, csr_kill=1, csr_newpc=0x200 with fe1_stall=0 -> fe0_read_req=0; the following cycle requests 0x200.
- Entries at 0x10 and 0x10+BTB_ENTRIES:
  - Alias: install both -> only the second hits.
  - Flush: csr_btb_flush together with an update -> no hits afterwards.
  - Wrap: pc 0x3FFFFFFF issued -> next addr 0.

Source files
------------

// File: rtl/fe_pkg.sv
// Shared types and helpers for the fetch0 stage and its branch target buffer.
package fe_pkg;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned CTR_W  = 2;

    localparam logic [CTR_W-1:0] CTR_WEAK_TAKEN = 2'b10;

    // The tag field is a full word address; only the bits above the index are compared.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] tag;
        logic [ADDR_W-1:0] target;
        logic [CTR_W-1:0]  ctr;
    } btb_entry_t;

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/stage_fetch0_btb_if.sv
// Fetch0 -> fetch1/icache request channel.
interface stage_fetch0_btb_if;
    import fe_pkg::*;

    logic              fe0_valid;
    logic              fe0_read_req;
    logic [8:0]        fe0_read_asid;
    logic [ADDR_W-1:0] fe0_read_addr;
    logic              fe0_pred_taken;
    logic [ADDR_W-1:0] fe0_pred_target;
    logic              fe1_stall;

    modport master (
        output fe0_valid, fe0_read_req, fe0_read_asid, fe0_read_addr,
               fe0_pred_taken, fe0_pred_target,
        input  fe1_stall
    );

    modport slave (
        input  fe0_valid, fe0_read_req, fe0_read_asid, fe0_read_addr,
               fe0_pred_taken, fe0_pred_target,
        output fe1_stall
    );

endinterface

// File: rtl/fe_btb.sv
// Direct-mapped BTB: combinational lookup, decode training and flush at the next edge.
module fe_btb
    import fe_pkg::*;
#(
    parameter int unsigned ENTRIES = 16
) (
    input  logic              clk_core,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic              lookup_taken,
    output logic [ADDR_W-1:0] lookup_target,
    input  logic              upd,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              flush
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    btb_entry_t mem [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             upd_hit;

    function automatic logic tag_eq(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return (a >> IDX_W) == (b >> IDX_W);
    endfunction

    assign rd_idx = lookup_addr[IDX_W-1:0];
    assign wr_idx = upd_pc[IDX_W-1:0];

    assign hit           = mem[rd_idx].valid & tag_eq(mem[rd_idx].tag, lookup_addr);
    assign lookup_taken  = mem[rd_idx].ctr[1];
    assign lookup_target = mem[rd_idx].target;

    assign upd_hit = mem[wr_idx].valid & tag_eq(mem[wr_idx].tag, upd_pc);

    // Flush wins over a same-cycle training write.
    always_ff @(posedge clk_core) begin
        if (!reset_n || flush) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem[IDX_W'(i)].valid <= 1'b0;
            end
        end else if (upd) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    mem[wr_idx].ctr    <= sat_inc(mem[wr_idx].ctr);
                    mem[wr_idx].target <= upd_target;
                end else begin
                    mem[wr_idx].ctr    <= sat_dec(mem[wr_idx].ctr);
                end
            end else if (upd_taken) begin
                mem[wr_idx] <= '{valid: 1'b1, tag: upd_pc, target: upd_target,
                                 ctr: CTR_WEAK_TAKEN};
            end
        end
    end

endmodule

// File: rtl/stage_fetch0_btb.sv
// Fetch-address generator: csr > decode redirect > BTB prediction > sequential.
module stage_fetch0_btb
    import fe_pkg::*;
#(
    parameter int unsigned       BTB_ENTRIES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = 30'h0
) (
    input  logic                    clk_core,
    input  logic                    reset_n,
    stage_fetch0_btb_if.master      fe,
    input  logic                    de_setpc,
    input  logic [ADDR_W-1:0]       de_newpc,
    input  logic                    de_btb_update,
    input  logic [ADDR_W-1:0]       de_btb_pc,
    input  logic                    de_btb_taken,
    input  logic [ADDR_W-1:0]       de_btb_target,
    input  logic                    csr_kill,
    input  logic                    csr_setpc,
    input  logic [ADDR_W-1:0]       csr_newpc,
    input  logic [31:0]             csr_satp,
    input  logic                    csr_btb_flush
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] addr;
    logic              read_req;
    logic              btb_hit;
    logic              btb_taken;
    logic [ADDR_W-1:0] btb_target;
    logic              pred_taken;
    logic              unused_satp;

    assign addr = csr_setpc ? csr_newpc :
                  de_setpc  ? de_newpc  : pc_q;

    // A csr redirect may issue past a fetch1 stall; a kill squashes everything.
    assign read_req   = reset_n & ~csr_kill & (csr_setpc | ~fe.fe1_stall);
    assign pred_taken = read_req & btb_hit & btb_taken;

    fe_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk_core      (clk_core),
        .reset_n       (reset_n),
        .lookup_addr   (addr),
        .hit           (btb_hit),
        .lookup_taken  (btb_taken),
        .lookup_target (btb_target),
        .upd           (de_btb_update),
        .upd_pc        (de_btb_pc),
        .upd_taken     (de_btb_taken),
        .upd_target    (de_btb_target),
        .flush         (csr_btb_flush)
    );

    // An unissued redirect is parked in pc_q and fetched on the first free cycle.
    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else if (read_req) begin
            pc_q <= pred_taken ? btb_target : addr + 30'd1;
        end else if (csr_setpc || de_setpc) begin
            pc_q <= addr;
        end
    end

    assign fe.fe0_read_req    = read_req;
    assign fe.fe0_valid       = read_req;
    assign fe.fe0_read_addr   = addr;
    assign fe.fe0_read_asid   = csr_satp[30:22];
    assign fe.fe0_pred_taken  = pred_taken;
    assign fe.fe0_pred_target = btb_target;

    assign unused_satp = ^{csr_satp[31], csr_satp[21:0]};

endmodule

// File: tb/tb_stage_fetch0_btb.sv
// Directed, table-driven bench for stage_fetch0_btb (BTB_ENTRIES=16, RESET_PC=0).
module tb_stage_fetch0_btb;

    typedef struct {
        logic        stall;
        logic        kill;
        logic        csr_set;
        logic [29:0] csr_pc;
        logic        de_set;
        logic [29:0] de_pc;
        logic        upd;
        logic        upd_tk;
        logic [29:0] upd_pc;
        logic [29:0] upd_tgt;
        logic        flush;
        logic        exp_req;
        logic [29:0] exp_addr;
        logic        exp_pred;
        logic [29:0] exp_tgt;
    } vec_t;

    logic        clk_core;
    logic        reset_n;
    logic        de_setpc;
    logic [29:0] de_newpc;
    logic        de_btb_update;
    logic [29:0] de_btb_pc;
    logic        de_btb_taken;
    logic [29:0] de_btb_target;
    logic        csr_kill;
    logic        csr_setpc;
    logic [29:0] csr_newpc;
    logic [31:0] csr_satp;
    logic        csr_btb_flush;

    int n_checks;
    int n_fail;
    vec_t vecs[$];

    stage_fetch0_btb_if fe_if ();

    stage_fetch0_btb #(
        .BTB_ENTRIES (16),
        .RESET_PC    (30'h0)
    ) dut (
        .clk_core      (clk_core),
        .reset_n       (reset_n),
        .fe            (fe_if),
        .de_setpc      (de_setpc),
        .de_newpc      (de_newpc),
        .de_btb_update (de_btb_update),
        .de_btb_pc     (de_btb_pc),
        .de_btb_taken  (de_btb_taken),
        .de_btb_target (de_btb_target),
        .csr_kill      (csr_kill),
        .csr_setpc     (csr_setpc),
        .csr_newpc     (csr_newpc),
        .csr_satp      (csr_satp),
        .csr_btb_flush (csr_btb_flush)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, got, exp);
        end
    endtask

    task automatic add(input logic stall, input logic kill, input logic csr_set, input int csr_pc,
                       input logic de_set, input int de_pc, input logic upd, input logic upd_tk,
                       input int upd_pc, input int upd_tgt, input logic flush,
                       input logic exp_req, input int exp_addr, input logic exp_pred,
                       input int exp_tgt);
        vec_t v;
        v.stall = stall;   v.kill = kill;
        v.csr_set = csr_set; v.csr_pc = 30'(csr_pc);
        v.de_set = de_set; v.de_pc = 30'(de_pc);
        v.upd = upd; v.upd_tk = upd_tk; v.upd_pc = 30'(upd_pc); v.upd_tgt = 30'(upd_tgt);
        v.flush = flush;
        v.exp_req = exp_req; v.exp_addr = 30'(exp_addr);
        v.exp_pred = exp_pred; v.exp_tgt = 30'(exp_tgt);
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        fe_if.fe1_stall = v.stall;
        csr_kill        = v.kill;
        csr_setpc       = v.csr_set;
        csr_newpc       = v.csr_pc;
        de_setpc        = v.de_set;
        de_newpc        = v.de_pc;
        de_btb_update   = v.upd;
        de_btb_taken    = v.upd_tk;
        de_btb_pc       = v.upd_pc;
        de_btb_target   = v.upd_tgt;
        csr_btb_flush   = v.flush;
    endtask

    initial begin
        vec_t idle;
        n_checks = 0;
        n_fail   = 0;
        idle = '{default: '0};

        //   stl kil csS csPC   deS dePC        upd tk updPC  tgt   fl  req addr        prd tgt
        add(0, 0, 0, 0,     0, 0,           0, 0, 0,     0,    0,  1, 'h0,         0, 0);
        add(0, 0, 0, 0,     0, 0,           0, 0, 0,     0,    0,  1, 'h1,         0, 0);
        add(0, 0, 0, 0,     0, 0,           0, 0, 0,     0,    0,  1, 'h2,         0, 0);
        add(0, 0, 0, 0,     0, 0,           0, 0, 0,     0,    0,  1, 'h3,         0, 0);
        add(0, 0, 0, 0,     0, 0,           0, 0, 0,     0,    0,  1, 'h4,         0, 0);
        add(1, 0, 0, 0,     0, 0,           0, 0, 0,     0,    0,  0, 'h5,         0, 0);
        add(1, 0, 0, 0,     0, 0,           0, 0, 0,     0,    0,  0, 'h5,         0, 0);
        add(0, 0, 0, 0,     0, 0,           0, 0, 0,     0,    0,  1, 'h5,         0, 0);
        add(1, 0, 0, 0,     1, 'h40,        0, 0, 0,     0,    0,  0, 'h40,        0, 0);
        add(1, 0, 0, 0,     0, 0,           0, 0, 0,     0,    0,  0, 'h40,        0, 0);
        add(0, 0, 0, 0,     0, 0,           0, 0, 0,     0,    0,  1, 'h40,        0, 0);
        add(1, 0, 0, 0,     0, 0,           1, 1, 'h10,  'h80, 0,  0, 'h41,        0, 0);
        add(0, 0, 0, 0,     1, 'h10,        0, 0, 0,     0,    0,  1, 'h10,        1, 'h80);
        add(0, 0, 0, 0,     0, 0,           0, 0, 0,     0,    0,  1, 'h80,        0, 0);
        add(1, 0, 0, 0,     0, 0,           1, 0, 'h10,  'h0,  0,  0, 'h81,        0, 0);
        add(1, 0, 0, 0,     0, 0,           1, 0, 'h10,  'h0,  0,  0, 'h81,        0, 0);
        add(0, 0, 0, 0,     1, 'h10,        0, 0, 0,     0,    0,  1, 'h10,        0, 0);
        add(0, 0, 0, 0,     0, 0,           0, 0, 0,     0,    0,  1, 'h11,        0, 0);
        add(0, 1, 1, 'h200, 0, 0,           0, 0, 0,     0,    0,  0, 'h200,       0, 0);
        add(0, 0, 0, 0,     0, 0,           0, 0, 0,     0,    0,  1, 'h200,       0, 0);
        // same-cycle training is invisible to the lookup
        add(0, 0, 0, 0,     1, 'h10,        1, 1, 'h10,  'h90, 0,  1, 'h10,        0, 0);
        add(1, 0, 0, 0,     0, 0,           1, 1, 'h10,  'h90, 0,  0, 'h11,        0, 0);
        add(0, 0, 0, 0,     1, 'h10,        0, 0, 0,     0,    0,  1, 'h10,        1, 'h90);
        // alias 0x20 evicts 0x10
        add(1, 0, 0, 0,     0, 0,           1, 1, 'h20,  'ha0, 0,  0, 'h90,        0, 0);
        add(0, 0, 0, 0,     1, 'h20,        0, 0, 0,     0,    0,  1, 'h20,        1, 'ha0);
        add(0, 0, 0, 0,     1, 'h10,        0, 0, 0,     0,    0,  1, 'h10,        0, 0);
        // flush beats a simultaneous allocate
        add(1, 0, 0, 0,     0, 0,           1, 1, 'h20,  'hb0, 1,  0, 'h11,        0, 0);
        add(0, 0, 0, 0,     1, 'h20,        0, 0, 0,     0,    0,  1, 'h20,        0, 0);
        add(0, 0, 0, 0,     1, 'h10,        0, 0, 0,     0,    0,  1, 'h10,        0, 0);
        // 30-bit wrap
        add(0, 0, 0, 0,     1, 'h3fffffff,  0, 0, 0,     0,    0,  1, 'h3fffffff,  0, 0);
        add(0, 0, 0, 0,     0, 0,           0, 0, 0,     0,    0,  1, 'h0,         0, 0);
        // csr beats decode and issues through a stall
        add(1, 0, 1, 'h300, 1, 'h50,        0, 0, 0,     0,    0,  1, 'h300,       0, 0);
        add(0, 0, 0, 0,     0, 0,           0, 0, 0,     0,    0,  1, 'h301,       0, 0);
        // kill squashes a sequential request
        add(0, 1, 0, 0,     0, 0,           0, 0, 0,     0,    0,  0, 'h302,       0, 0);
        add(0, 0, 0, 0,     0, 0,           0, 0, 0,     0,    0,  1, 'h302,       0, 0);

        drive(idle);
        csr_satp = 32'h5A5A_5A5A;
        reset_n  = 1'b0;

        repeat (2) @(negedge clk_core);
        #1;
        chk("reset_req",  -1, 32'(fe_if.fe0_read_req),   32'd0);
        chk("reset_pred", -1, 32'(fe_if.fe0_pred_taken), 32'd0);
        chk("asid",       -1, 32'(fe_if.fe0_read_asid),  32'(csr_satp[30:22]));

        @(negedge clk_core);
        reset_n = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            chk("read_req", i, 32'(fe_if.fe0_read_req), 32'(vecs[i].exp_req));
            chk("valid",    i, 32'(fe_if.fe0_valid),    32'(vecs[i].exp_req));
            chk("addr",     i, 32'(fe_if.fe0_read_addr), 32'(vecs[i].exp_addr));
            chk("pred",     i, 32'(fe_if.fe0_pred_taken), 32'(vecs[i].exp_pred));
            if (vecs[i].exp_pred)
                chk("target", i, 32'(fe_if.fe0_pred_target), 32'(vecs[i].exp_tgt));
            @(negedge clk_core);
        end

        // Mid-run reset: request suppressed while low, then fetch restarts at RESET_PC.
        drive(idle);
        reset_n = 1'b0;
        #1;
        chk("midreset_req",  100, 32'(fe_if.fe0_read_req),   32'd0);
        chk("midreset_pred", 100, 32'(fe_if.fe0_pred_taken), 32'd0);
        @(negedge clk_core);
        reset_n = 1'b1;
        #1;
        chk("restart_req",  101, 32'(fe_if.fe0_read_req),  32'd1);
        chk("restart_addr", 101, 32'(fe_if.fe0_read_addr), 32'd0);
        @(negedge clk_core);
        #1;
        chk("restart_next", 102, 32'(fe_if.fe0_read_addr), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
